// File: rtl/execute_cycle_pkg.sv
// Shared encodings and helpers for the RV32I execute stage.
// The iterative multiplier is built only when RV_MUL_EN is defined.
package execute_cycle_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_MUL = 3'b111;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int MUL_STEPS = 32;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        result_src;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [31:0] pc_plus4;
    logic [4:0]  rd;
  } exmem_t;

  // Code 11 falls back to the register file value.
  function automatic logic [31:0] fwd_mux(input logic [1:0] sel, input logic [31:0] rf,
                                          input logic [31:0] wb, input logic [31:0] mem);
    logic [31:0] r;
    case (sel)
      FWD_WB:  r = wb;
      FWD_MEM: r = mem;
      default: r = rf;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] alu_basic(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_SLT: r = {31'b0, ($signed(a) < $signed(b))};
      default: r = 32'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/execute_cycle_if.sv
// ID/EX inputs, forwarding inputs and EX/MEM outputs of the execute stage.
// slave is the execute stage side, master is the upstream/downstream side.
interface execute_cycle_if;
  import execute_cycle_pkg::*;

  logic        RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_ExtE, PCE, PCPlus4E;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ResultW;

  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        StallE;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RD_M;
  mul_state_e  MulStateE;

  // No valid/ready: the stage advances every clock; StallE asks upstream to hold ID/EX.
  modport slave (
    input  RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE, ALUControlE,
           RD1_E, RD2_E, Imm_ExtE, PCE, PCPlus4E, RD_E, ForwardAE, ForwardBE, ResultW,
    output PCSrcE, PCTargetE, StallE, RegWriteM, MemWriteM, ResultSrcM,
           ALUResultM, WriteDataM, PCPlus4M, RD_M, MulStateE
  );

  modport master (
    output RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE, ALUControlE,
           RD1_E, RD2_E, Imm_ExtE, PCE, PCPlus4E, RD_E, ForwardAE, ForwardBE, ResultW,
    input  PCSrcE, PCTargetE, StallE, RegWriteM, MemWriteM, ResultSrcM,
           ALUResultM, WriteDataM, PCPlus4M, RD_M, MulStateE
  );
endinterface

// File: rtl/execute_cycle_mul_iter.sv
// Iterative shift-add multiplier (low 32 bits), one step per clock.
// Instantiated by execute_cycle only when RV_MUL_EN is defined.
module mul_iter
  import execute_cycle_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        mul_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] product_o,
  output mul_state_e  state_o
);

  mul_state_e  state_q;
  logic [4:0]  cnt_q;
  logic [31:0] a_q, b_q, acc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MUL_IDLE;
      cnt_q   <= 5'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      acc_q   <= 32'd0;
    end else begin
      case (state_q)
        MUL_IDLE: begin
          if (mul_i) begin
            // Operands are latched because forwarding sources move during the stall.
            a_q     <= op_a_i;
            b_q     <= op_b_i;
            acc_q   <= 32'd0;
            cnt_q   <= 5'd0;
            state_q <= MUL_BUSY;
          end
        end
        MUL_BUSY: begin
          if (b_q[0]) acc_q <= acc_q + a_q;
          a_q   <= {a_q[30:0], 1'b0};
          b_q   <= {1'b0, b_q[31:1]};
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'(MUL_STEPS - 1)) state_q <= MUL_DONE;
        end
        MUL_DONE: state_q <= MUL_IDLE;
        default:  state_q <= MUL_IDLE;
      endcase
    end
  end

  assign busy_o    = ((state_q == MUL_IDLE) && mul_i) || (state_q == MUL_BUSY);
  assign done_o    = (state_q == MUL_DONE);
  assign product_o = acc_q;
  assign state_o   = state_q;

endmodule

// File: rtl/execute_cycle.sv
// RV32I execute stage: operand forwarding, ALU, branch resolve, EX/MEM register.
// Define RV_MUL_EN to add the iterative multiplier (ALU code 111) and its stall.
module execute_cycle
  import execute_cycle_pkg::*;
(
  input  logic clk,
  input  logic reset,
  execute_cycle_if.slave ex
);

  logic [31:0] src_a, src_b, write_data, alu_base, alu_result;
  logic        stall, zero;
  mul_state_e  mul_state;
  exmem_t      exm_d, exm_q;

  assign src_a      = fwd_mux(ex.ForwardAE, ex.RD1_E, ex.ResultW, ex.ALUResultM);
  assign write_data = fwd_mux(ex.ForwardBE, ex.RD2_E, ex.ResultW, ex.ALUResultM);
  assign src_b      = ex.ALUSrcE ? ex.Imm_ExtE : write_data;
  assign alu_base   = alu_basic(ex.ALUControlE, src_a, src_b);

`ifdef RV_MUL_EN
  logic        mul_done;
  logic [31:0] mul_product;

  mul_iter u_mul (
    .clk       (clk),
    .reset     (reset),
    .mul_i     (ex.ALUControlE == ALU_MUL),
    .op_a_i    (src_a),
    .op_b_i    (src_b),
    .busy_o    (stall),
    .done_o    (mul_done),
    .product_o (mul_product),
    .state_o   (mul_state)
  );

  assign alu_result = (ex.ALUControlE == ALU_MUL) ? (mul_done ? mul_product : 32'd0)
                                                  : alu_base;
`else
  assign stall      = 1'b0;
  assign mul_state  = MUL_IDLE;
  assign alu_result = alu_base;
`endif

  assign zero         = (alu_result == 32'd0);
  assign ex.PCSrcE    = ex.BranchE & zero & ~stall;
  assign ex.PCTargetE = ex.PCE + ex.Imm_ExtE;
  assign ex.StallE    = stall;
  assign ex.MulStateE = mul_state;

  // A stalled cycle sends an all-zero bubble downstream.
  always_comb begin
    exm_d = '0;
    if (!stall) begin
      exm_d.reg_write  = ex.RegWriteE;
      exm_d.mem_write  = ex.MemWriteE;
      exm_d.result_src = ex.ResultSrcE;
      exm_d.alu_result = alu_result;
      exm_d.write_data = write_data;
      exm_d.pc_plus4   = ex.PCPlus4E;
      exm_d.rd         = ex.RD_E;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) exm_q <= '0;
    else       exm_q <= exm_d;
  end

  assign ex.RegWriteM  = exm_q.reg_write;
  assign ex.MemWriteM  = exm_q.mem_write;
  assign ex.ResultSrcM = exm_q.result_src;
  assign ex.ALUResultM = exm_q.alu_result;
  assign ex.WriteDataM = exm_q.write_data;
  assign ex.PCPlus4M   = exm_q.pc_plus4;
  assign ex.RD_M       = exm_q.rd;

endmodule
